// File: rtl/db_pkg.sv
// Shared definitions for the endpoint data buffer write side.
package db_pkg;

    localparam int unsigned DB_DEPTH  = 64;
    localparam int unsigned DB_ADDR_W = 6;
    localparam int unsigned DB_DATA_W = 8;

    // Which source currently owns the buffer contents.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TX_OWN = 2'd1,
        RX_OWN = 2'd2
    } db_owner_t;

endpackage

// File: rtl/db_occupancy_counter.sv
// Occupancy counter for the endpoint buffer: 0..DEPTH.
// A decrement at zero is ignored; an increment together with an effective
// decrement leaves the count unchanged.
module db_occupancy_counter #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             w_dec_eff;

    // Decrement only counts when there is something to remove.
    always_comb begin
        w_dec_eff = dec & (r_count != '0);
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc & ~w_dec_eff) begin
            r_count <= r_count + 1'b1;
        end else if (~inc & w_dec_eff) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign full  = (r_count == FULL_VAL);
    assign empty = (r_count == '0);

endmodule

// File: rtl/db_write_controller.sv
// Write-side controller for the shared endpoint data buffer.
// Arbitrates TX/RX byte stores, generates registered buffer writes and
// tracks occupancy and direction ownership.
// Optional feature macro: DB_ALMOST_FULL_EN (adds almost_full output).
module db_write_controller
    import db_pkg::*;
#(
    parameter int unsigned DEPTH  = DB_DEPTH,
    parameter int unsigned ADDR_W = DB_ADDR_W,
    parameter int unsigned DATA_W = DB_DATA_W
`ifdef DB_ALMOST_FULL_EN
    ,
    parameter int unsigned ALMOST_FULL_LVL = 60
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              store_TX_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              store_RX_packet_data,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              buffer_decrement,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_sel,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              buffer_full,
    output logic              buffer_empty,
    output logic              write_error
`ifdef DB_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] OCC_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   r_wr_ptr;
    logic              r_w_en;
    logic [ADDR_W-1:0] r_w_sel;
    logic [DATA_W-1:0] r_w_data;
    logic              r_write_error;
    db_owner_t         r_state;

    logic              w_clear;
    logic              w_any;
    logic              w_permit;
    logic              w_accept;
    logic              w_reject;
    logic              w_release;
    logic [DATA_W-1:0] w_byte;

    assign w_clear = reset | flush;

    // Store selection (TX wins), acceptance and ownership release.
    always_comb begin
        w_any = store_TX_data | store_RX_packet_data;
        if (store_TX_data) begin
            w_permit = (r_state != RX_OWN);
        end else begin
            w_permit = (r_state != TX_OWN);
        end
        w_accept  = w_any & ~buffer_full & w_permit;
        // An RX strobe shadowed by a same-cycle TX strobe is also a rejection.
        w_reject  = (w_any & ~w_accept) | (store_TX_data & store_RX_packet_data);
        w_release = (buffer_occupancy == OCC_ONE) & buffer_decrement & ~w_accept;
        w_byte    = store_TX_data ? tx_data : rx_packet_data;
    end

    // Registered buffer write port and write pointer.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_w_en   <= 1'b0;
            r_w_sel  <= '0;
            r_w_data <= '0;
        end else begin
            r_w_en <= w_accept;
            if (w_accept) begin
                r_w_sel  <= r_wr_ptr[ADDR_W-1:0];
                r_w_data <= w_byte;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Sticky rejected-store flag.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_write_error <= 1'b0;
        end else if (w_reject) begin
            r_write_error <= 1'b1;
        end
    end

    // Direction ownership: claimed by the first accepted store, released on empty.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= store_TX_data ? TX_OWN : RX_OWN;
                    end
                end
                TX_OWN, RX_OWN: begin
                    if (w_release) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    db_occupancy_counter #(
        .DEPTH (DEPTH),
        .CNT_W (ADDR_W + 1)
    ) u_occ (
        .clk   (clk),
        .clear (w_clear),
        .inc   (w_accept),
        .dec   (buffer_decrement),
        .count (buffer_occupancy),
        .full  (buffer_full),
        .empty (buffer_empty)
    );

    assign w_en        = r_w_en;
    assign w_sel       = r_w_sel;
    assign w_data      = r_w_data;
    assign write_error = r_write_error;

`ifdef DB_ALMOST_FULL_EN
    assign almost_full = (buffer_occupancy >= (ADDR_W+1)'(ALMOST_FULL_LVL));
`endif

endmodule

// File: tb/tb_db_write_controller.sv
// Self-checking bench for db_write_controller: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the buffer.
`timescale 1ns/1ps
module tb_db_write_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       store_TX_data = 1'b0;
    logic [7:0] tx_data = '0;
    logic       store_RX_packet_data = 1'b0;
    logic [7:0] rx_packet_data = '0;
    logic       buffer_decrement = 1'b0;
    logic       w_en;
    logic [5:0] w_sel;
    logic [7:0] w_data;
    logic [6:0] buffer_occupancy;
    logic       buffer_full;
    logic       buffer_empty;
    logic       write_error;
`ifdef DB_ALMOST_FULL_EN
    logic       almost_full;
`endif

    db_write_controller #(
        .DEPTH  (64),
        .ADDR_W (6),
        .DATA_W (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .store_TX_data        (store_TX_data),
        .tx_data              (tx_data),
        .store_RX_packet_data (store_RX_packet_data),
        .rx_packet_data       (rx_packet_data),
        .buffer_decrement     (buffer_decrement),
        .w_en                 (w_en),
        .w_sel                (w_sel),
        .w_data               (w_data),
        .buffer_occupancy     (buffer_occupancy),
        .buffer_full          (buffer_full),
        .buffer_empty         (buffer_empty),
        .write_error          (write_error)
`ifdef DB_ALMOST_FULL_EN
        ,
        .almost_full          (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Behavioural model: owner 0 = nobody, 1 = TX path, 2 = RX path.
    int          m_occ   = 0;
    int          m_ptr   = 0;
    int          m_owner = 0;
    int          m_wen   = 0;
    int          m_sel   = 0;
    int          m_data  = 0;
    int          m_err   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit tx, input int txd, input bit rx, input int rxd,
                              input bit dec, input bit clr);
        bit any, permit, acc;
        if (clr) begin
            m_occ = 0; m_ptr = 0; m_owner = 0;
            m_wen = 0; m_sel = 0; m_data = 0; m_err = 0;
            return;
        end
        any    = tx || rx;
        permit = tx ? (m_owner != 2) : (m_owner != 1);
        acc    = any && (m_occ < 64) && permit;
        if (tx && rx) m_err = 1;
        if (any && !acc) m_err = 1;
        m_wen = acc ? 1 : 0;
        if (acc) begin
            m_sel  = m_ptr % 64;
            m_data = tx ? txd : rxd;
            m_ptr  = (m_ptr + 1) % 128;
            if (m_owner == 0) m_owner = tx ? 1 : 2;
        end
        if (acc) m_occ = m_occ + 1;
        if (dec && (m_occ - (acc ? 1 : 0)) > 0) m_occ = m_occ - 1;
        if (m_occ == 0) m_owner = 0;
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare every output.
    task automatic cycle(input bit tx, input logic [7:0] txd, input bit rx, input logic [7:0] rxd,
                         input bit dec, input bit fl, input bit rst);
        store_TX_data        = tx;
        tx_data              = txd;
        store_RX_packet_data = rx;
        rx_packet_data       = rxd;
        buffer_decrement     = dec;
        flush                = fl;
        reset                = rst;
        @(posedge clk);
        #1;
        model_step(tx, int'(txd), rx, int'(rxd), dec, fl || rst);
        check("w_en",  32'(w_en),             32'(m_wen));
        check("w_sel", 32'(w_sel),            32'(m_sel));
        check("w_data", 32'(w_data),          32'(m_data));
        check("occ",   32'(buffer_occupancy), 32'(m_occ));
        check("full",  32'(buffer_full),      32'(m_occ == 64));
        check("empty", 32'(buffer_empty),     32'(m_occ == 0));
        check("err",   32'(write_error),      32'(m_err));
`ifdef DB_ALMOST_FULL_EN
        check("afull", 32'(almost_full),      32'(m_occ >= 60));
`endif
        store_TX_data        = 1'b0;
        store_RX_packet_data = 1'b0;
        buffer_decrement     = 1'b0;
        flush                = 1'b0;
        reset                = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tx_store(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rx_store(input logic [7:0] d);
        cycle(1'b0, 8'h00, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state.
        do_reset();
        check("rst_occ", 32'(buffer_occupancy), 32'd0);
        check("rst_empty", 32'(buffer_empty), 32'd1);

        // Three TX stores land at indices 0,1,2 one cycle later.
        tx_store(8'hA1);
        check("tp1_sel0", 32'(w_sel), 32'd0);
        tx_store(8'hA2);
        check("tp1_data1", 32'(w_data), 32'hA2);
        tx_store(8'hA3);
        check("tp1_sel2", 32'(w_sel), 32'd2);
        idle();
        check("tp1_occ", 32'(buffer_occupancy), 32'd3);
        check("tp1_wen_hold", 32'(w_en), 32'd0);
        // TX ownership shows as RX rejection.
        rx_store(8'h11);
        check("tp1_rx_rej", 32'(write_error), 32'd1);

        // Fill to 64, then a 65th store is rejected.
        do_reset();
        for (int i = 0; i < 64; i++) tx_store(8'(i));
        check("tp2_full", 32'(buffer_full), 32'd1);
        check("tp2_occ", 32'(buffer_occupancy), 32'd64);
        tx_store(8'hFF);
        check("tp2_no_wen", 32'(w_en), 32'd0);
        check("tp2_err", 32'(write_error), 32'd1);

        // RX ownership rejects TX; draining to zero returns to IDLE.
        do_reset();
        rx_store(8'h21);
        rx_store(8'h22);
        tx_store(8'h33);
        check("tp3_tx_rej", 32'(write_error), 32'd1);
        check("tp3_occ2", 32'(buffer_occupancy), 32'd2);
        drain();
        drain();
        check("tp3_occ0", 32'(buffer_occupancy), 32'd0);
        tx_store(8'h44);
        check("tp3_idle_tx", 32'(w_en), 32'd1);

        // Same-cycle store and decrement at occupancy 5.
        do_reset();
        for (int i = 0; i < 5; i++) tx_store(8'h50 + 8'(i));
        cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("tp4_occ", 32'(buffer_occupancy), 32'd5);
        check("tp4_wen", 32'(w_en), 32'd1);

        // Fill, drain, store: index wraps back to 0.
        do_reset();
        for (int i = 0; i < 64; i++) tx_store(8'(i));
        for (int i = 0; i < 64; i++) drain();
        drain();
        check("tp5_sat0", 32'(buffer_occupancy), 32'd0);
        tx_store(8'h5C);
        check("tp5_wrap", 32'(w_sel), 32'd0);
        check("tp5_data", 32'(w_data), 32'h5C);

        // Flush wins over a same-cycle store.
        do_reset();
        for (int i = 0; i < 10; i++) tx_store(8'h60 + 8'(i));
        cycle(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("tp6_occ", 32'(buffer_occupancy), 32'd0);
        check("tp6_wen", 32'(w_en), 32'd0);
        check("tp6_err", 32'(write_error), 32'd0);
        rx_store(8'h01);
        check("tp6_idle_rx", 32'(w_en), 32'd1);

        // Randomized traffic in fill-heavy and drain-heavy phases.
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            int unsigned p_st;
            int unsigned p_dec;
            p_st  = (ph % 2 == 0) ? 80 : 25;
            p_dec = (ph % 2 == 0) ? 20 : 75;
            for (int i = 0; i < 300; i++) begin
                bit tx, rx, dec, fl, rst;
                tx  = ($urandom_range(99) < p_st / 2);
                rx  = ($urandom_range(99) < p_st / 2);
                dec = ($urandom_range(99) < p_dec);
                fl  = ($urandom_range(199) == 0);
                rst = ($urandom_range(399) == 0);
                cycle(tx, 8'($urandom), rx, 8'($urandom), dec, fl, rst);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
